// File: rtl/fft_agu_pkg.sv
// Shared types and helpers for the run-time sized radix-2 DIT FFT address generator.
// Combinational only; no state, no flow control.
package fft_agu_pkg;

  localparam int DEF_MAX_M = 9;
  localparam int DEF_MIN_M = 2;

  typedef enum logic [2:0] {IDLE, LOAD, ISSUE, FLUSH, DONE} state_t;

  // Reverses the low m bits of value; bits at and above m come back as 0.
  function automatic logic [31:0] bitrev(input logic [31:0] value, input int m);
    logic [31:0] r;
    r = '0;
    for (int i = 0; i < 32; i++) begin
      if (i < m) r[i] = value[5'(m - 1 - i)];
    end
    return r;
  endfunction

endpackage

// File: rtl/fft_agu_delay.sv
// Write-side delay line: carries {valid, adr_a, adr_b} from issue to writeback.
// Latency LAT cycles; no backpressure, shifts every cycle.
module fft_agu_delay #(
  parameter int AW  = 9,
  parameter int LAT = 2
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_vld,
  input  logic [AW-1:0] in_adr_a,
  input  logic [AW-1:0] in_adr_b,
  output logic          out_vld,
  output logic [AW-1:0] out_adr_a,
  output logic [AW-1:0] out_adr_b
);

  logic [LAT-1:0]         vld_q;
  logic [LAT-1:0][AW-1:0] a_q;
  logic [LAT-1:0][AW-1:0] b_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_q <= '0;
      a_q   <= '0;
      b_q   <= '0;
    end else begin
      vld_q[0] <= in_vld;
      a_q[0]   <= in_adr_a;
      b_q[0]   <= in_adr_b;
      for (int i = 1; i < LAT; i++) begin
        vld_q[i] <= vld_q[i-1];
        a_q[i]   <= a_q[i-1];
        b_q[i]   <= b_q[i-1];
      end
    end
  end

  assign out_vld   = vld_q[LAT-1];
  assign out_adr_a = a_q[LAT-1];
  assign out_adr_b = b_q[LAT-1];

endmodule

// File: rtl/fft_agu_ctrl.sv
// Sequencer and address generator for an in-place radix-2 DIT FFT over ping-pong banks.
// done rises m*(2^(m-1)+BF_LAT) cycles after an accepted start; start/load ignored while busy.
module fft_agu_ctrl
  import fft_agu_pkg::*;
#(
  parameter int bit_width = 16,
  parameter int MAX_M     = DEF_MAX_M,
  parameter int MIN_M     = DEF_MIN_M,
  parameter int BF_LAT    = 2,
  parameter int MW        = $clog2(MAX_M + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             load,
  input  logic [MW-1:0]    m_sel,
  input  logic [MAX_M-1:0] rd_adr,
  output logic             busy,
  output logic             done,
  output logic             err,
  output logic             rd_sel,
  output logic             we0,
  output logic             we1,
  output logic [MAX_M-1:0] adr0_a,
  output logic [MAX_M-1:0] adr0_b,
  output logic [MAX_M-1:0] adr1_a,
  output logic [MAX_M-1:0] adr1_b,
  output logic [MAX_M-2:0] twiddle_adr
);

  localparam int BW = MAX_M - 1;
  localparam int TW = MAX_M - 1;
  localparam int FW = $clog2(BF_LAT + 1) + ((bit_width > 0) ? 0 : 1);

  state_t           state, state_nxt;
  logic [MW-1:0]    m_q, s_q;
  logic [BW-1:0]    b_q, b_last;
  logic [FW-1:0]    fl_q;
  logic             err_q;
  logic             m_ok, can_start, go, reject;
  logic             last_b, last_fl, last_s, issue;
  logic [MAX_M-1:0] b_ext, span, pos, adr_a, adr_b, in_a, in_b;
  logic [TW-1:0]    tw;
  logic             d_vld;
  logic [MAX_M-1:0] d_adr_a, d_adr_b;
  int               m_lim;

  always_comb begin
    m_ok      = (int'(m_sel) >= MIN_M) && (int'(m_sel) <= MAX_M);
    can_start = (state == IDLE) || (state == LOAD) || (state == DONE);
    go        = can_start && !load && start && m_ok;
    reject    = can_start && !load && start && !m_ok;
    b_last    = BW'((1 << (int'(m_q) - 1)) - 1);
    last_b    = (b_q == b_last);
    last_fl   = (fl_q == FW'(BF_LAT - 1));
    last_s    = (s_q == m_q - 1'b1);
    issue     = (state == ISSUE);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE, LOAD, DONE: begin
        if (load)               state_nxt = LOAD;
        else if (go)            state_nxt = ISSUE;
        else if (state == LOAD) state_nxt = IDLE;
      end
      ISSUE:   if (last_b)  state_nxt = FLUSH;
      FLUSH:   if (last_fl) state_nxt = last_s ? DONE : ISSUE;
      default: state_nxt = IDLE;
    endcase
  end

  // Stage/butterfly/flush counters; b restarts at each stage, s only moves at a flush boundary.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      m_q   <= '0;
      s_q   <= '0;
      b_q   <= '0;
      fl_q  <= '0;
      err_q <= 1'b0;
    end else begin
      err_q <= reject;
      if (go) begin
        m_q <= m_sel;
        s_q <= '0;
        b_q <= '0;
      end else if (state == ISSUE) begin
        if (last_b) fl_q <= '0;
        else        b_q  <= b_q + 1'b1;
      end else if (state == FLUSH) begin
        fl_q <= fl_q + 1'b1;
        if (last_fl && !last_s) begin
          s_q <= s_q + 1'b1;
          b_q <= '0;
        end
      end
    end
  end

  always_comb begin
    b_ext = MAX_M'(b_q);
    span  = MAX_M'(1) << s_q;
    pos   = b_ext & (span - MAX_M'(1));
    adr_a = ((b_ext >> s_q) << (s_q + 1'b1)) | pos;
    adr_b = adr_a + span;
    tw    = TW'(pos << (MAX_M - 1 - int'(s_q)));
    in_a  = issue ? adr_a : '0;
    in_b  = issue ? adr_b : '0;
    m_lim = (int'(m_sel) > MAX_M) ? MAX_M : int'(m_sel);
  end

  fft_agu_delay #(
    .AW  (MAX_M),
    .LAT (BF_LAT)
  ) u_delay (
    .clk       (clk),
    .rst_n     (reset),
    .in_vld    (issue),
    .in_adr_a  (in_a),
    .in_adr_b  (in_b),
    .out_vld   (d_vld),
    .out_adr_a (d_adr_a),
    .out_adr_b (d_adr_b)
  );

  // Reads go to bank s[0], writebacks to the other bank, so ports never collide.
  always_comb begin
    busy        = 1'b0;
    done        = 1'b0;
    err         = err_q;
    rd_sel      = 1'b0;
    we0         = 1'b0;
    we1         = 1'b0;
    adr0_a      = '0;
    adr0_b      = '0;
    adr1_a      = '0;
    adr1_b      = '0;
    twiddle_adr = '0;
    case (state)
      LOAD: begin
        we0    = 1'b1;
        adr0_a = MAX_M'(bitrev(32'(rd_adr), m_lim));
      end
      ISSUE, FLUSH: begin
        busy   = 1'b1;
        rd_sel = s_q[0];
        if (s_q[0]) begin
          we0    = d_vld;
          adr0_a = d_adr_a;
          adr0_b = d_adr_b;
          if (issue) begin
            adr1_a = adr_a;
            adr1_b = adr_b;
          end
        end else begin
          we1    = d_vld;
          adr1_a = d_adr_a;
          adr1_b = d_adr_b;
          if (issue) begin
            adr0_a = adr_a;
            adr0_b = adr_b;
          end
        end
        if (issue) twiddle_adr = tw;
      end
      DONE: begin
        done   = 1'b1;
        rd_sel = m_q[0];
        if (m_q[0]) adr1_a = rd_adr;
        else        adr0_a = rd_adr;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_fft_agu_ctrl.sv
// Directed stimulus for fft_agu_ctrl, checked every cycle against a cycle-count model
// of the transform schedule, with literal checks that pin the model's arithmetic.
module tb_fft_agu_ctrl;

  localparam int MAX_M  = 9;
  localparam int MIN_M  = 2;
  localparam int BF_LAT = 2;
  localparam int MW     = $clog2(MAX_M + 1);

  logic             clk = 1'b0;
  logic             reset = 1'b0;
  logic             start = 1'b0;
  logic             load = 1'b0;
  logic [MW-1:0]    m_sel = '0;
  logic [MAX_M-1:0] rd_adr = '0;
  logic             busy, done, err, rd_sel, we0, we1;
  logic [MAX_M-1:0] adr0_a, adr0_b, adr1_a, adr1_b;
  logic [MAX_M-2:0] twiddle_adr;

  fft_agu_ctrl #(
    .bit_width (16),
    .MAX_M     (MAX_M),
    .MIN_M     (MIN_M),
    .BF_LAT    (BF_LAT),
    .MW        (MW)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .load        (load),
    .m_sel       (m_sel),
    .rd_adr      (rd_adr),
    .busy        (busy),
    .done        (done),
    .err         (err),
    .rd_sel      (rd_sel),
    .we0         (we0),
    .we1         (we1),
    .adr0_a      (adr0_a),
    .adr0_b      (adr0_b),
    .adr1_a      (adr1_a),
    .adr1_b      (adr1_b),
    .twiddle_adr (twiddle_adr)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  // Model: mode 0 idle, 1 load, 2 running (k cycles since start), 3 done.
  int md = 0;
  int mm = 0;
  int k = 0;
  int e_err = 0;

  function automatic int rev(int v, int n);
    int r = 0;
    for (int i = 0; i < n; i++) r = r * 2 + ((v >> i) & 1);
    return r;
  endfunction

  function automatic int lo_adr(int s, int j);
    return (j / (1 << s)) * (2 << s) + j % (1 << s);
  endfunction

  function automatic int tw_of(int s, int j);
    return (j % (1 << s)) * (1 << (MAX_M - 1 - s));
  endfunction

  function automatic int run_len(int m);
    return m * ((1 << (m - 1)) + BF_LAT);
  endfunction

  always @(posedge clk) begin
    if (!reset) begin
      md    = 0;
      e_err = 0;
    end else begin
      e_err = 0;
      if (md == 2) begin
        k++;
        if (k == run_len(mm)) md = 3;
      end else if (load) begin
        md = 1;
      end else if (start) begin
        if (m_sel >= MIN_M && m_sel <= MAX_M) begin
          mm = int'(m_sel);
          k  = 0;
          md = 2;
        end else begin
          e_err = 1;
          if (md == 1) md = 0;
        end
      end else if (md == 1) begin
        md = 0;
      end
    end
  end

  task automatic chk(string nm, int act, int exp);
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got %0d, want %0d at t=%0t", nm, act, exp, $time);
    end
  endtask

  task automatic pin(string nm, int act, int exp);
    vectors++;
    chk(nm, act, exp);
  endtask

  int eb, ed, ee, er, ew0, ew1, a0a, a0b, a1a, a1b, etw;
  int half, len, s, j, k2, s2, j2, lo;
  bit pinned = 1'b0;

  always @(negedge clk) begin
    if (!pinned) begin
      pinned = 1'b1;
      pin("pin_rev_1_3", rev(1, 3), 4);
      pin("pin_rev_3_3", rev(3, 3), 6);
      pin("pin_rev_6_3", rev(6, 3), 3);
      pin("pin_rev_5_9", rev(5, 9), 320);
      pin("pin_lo_0_3", lo_adr(0, 3), 6);
      pin("pin_lo_1_3", lo_adr(1, 3), 5);
      pin("pin_lo_2_1", lo_adr(2, 1), 1);
      pin("pin_tw_2_1", tw_of(2, 1), 64);
      pin("pin_tw_2_3", tw_of(2, 3), 192);
      pin("pin_len_3", run_len(3), 18);
      pin("pin_len_4", run_len(4), 40);
    end
    eb = 0; ed = 0; ee = 0; er = 0; ew0 = 0; ew1 = 0;
    a0a = 0; a0b = 0; a1a = 0; a1b = 0; etw = 0;
    if (reset) begin
      ee = e_err;
      case (md)
        1: begin
          ew0 = 1;
          a0a = rev(int'(rd_adr), int'(m_sel));
        end
        2: begin
          half = 1 << (mm - 1);
          len  = half + BF_LAT;
          s    = k / len;
          j    = k % len;
          eb   = 1;
          er   = s % 2;
          if (j < half) begin
            lo = lo_adr(s, j);
            if (s % 2 == 0) begin a0a = lo; a0b = lo + (1 << s); end
            else            begin a1a = lo; a1b = lo + (1 << s); end
            etw = tw_of(s, j);
          end
          if (k >= BF_LAT) begin
            k2 = k - BF_LAT;
            s2 = k2 / len;
            j2 = k2 % len;
            if (j2 < half) begin
              lo = lo_adr(s2, j2);
              if (s2 % 2 == 0) begin ew1 = 1; a1a = lo; a1b = lo + (1 << s2); end
              else             begin ew0 = 1; a0a = lo; a0b = lo + (1 << s2); end
            end
          end
        end
        3: begin
          ed = 1;
          er = mm % 2;
          if (mm % 2 == 1) a1a = int'(rd_adr);
          else             a0a = int'(rd_adr);
        end
        default: ;
      endcase
    end
    vectors++;
    chk("busy", int'(busy), eb);
    chk("done", int'(done), ed);
    chk("err", int'(err), ee);
    chk("rd_sel", int'(rd_sel), er);
    chk("we0", int'(we0), ew0);
    chk("we1", int'(we1), ew1);
    chk("adr0_a", int'(adr0_a), a0a);
    chk("adr0_b", int'(adr0_b), a0b);
    chk("adr1_a", int'(adr1_a), a1a);
    chk("adr1_b", int'(adr1_b), a1b);
    chk("twiddle_adr", int'(twiddle_adr), etw);
  end

  task automatic cyc();
    @(posedge clk);
    #2;
  endtask

  initial begin
    repeat (3) cyc();
    reset = 1'b1;
    cyc();

    // Rejected starts from IDLE: too small, then too large.
    m_sel = 4'd1; start = 1'b1; cyc(); start = 1'b0; cyc(); cyc();
    m_sel = 4'd10; start = 1'b1; cyc(); start = 1'b0; cyc();

    // Bit-reversed loading, m_sel used live.
    load = 1'b1; m_sel = 4'd3; cyc();
    rd_adr = 9'd1; cyc();
    rd_adr = 9'd3; cyc();
    rd_adr = 9'd6; cyc();
    m_sel = 4'd9; rd_adr = 9'd5; cyc();
    load = 1'b0; cyc();

    // load wins over start.
    load = 1'b1; start = 1'b1; m_sel = 4'd3; cyc();
    load = 1'b0; start = 1'b0; cyc(); cyc();

    // 8-point transform, then read out of bank 1.
    m_sel = 4'd3; start = 1'b1; cyc(); start = 1'b0;
    repeat (20) cyc();
    rd_adr = 9'd5; cyc();
    rd_adr = 9'd2; cyc();

    // 16-point transform with start/load pulsed while busy.
    m_sel = 4'd4; start = 1'b1; cyc(); start = 1'b0;
    repeat (5) cyc();
    load = 1'b1; start = 1'b1; cyc(); load = 1'b0; start = 1'b0;
    repeat (37) cyc();
    rd_adr = 9'd9; cyc();

    // Abort a 512-point transform mid-ISSUE.
    m_sel = 4'd9; start = 1'b1; cyc(); start = 1'b0;
    repeat (40) cyc();
    reset = 1'b0; cyc(); cyc();
    reset = 1'b1; cyc(); cyc();

    // Smallest legal size, then a rejected start from DONE, then reload.
    m_sel = 4'd2; start = 1'b1; cyc(); start = 1'b0;
    repeat (10) cyc();
    m_sel = 4'd0; start = 1'b1; cyc(); start = 1'b0;
    load = 1'b1; m_sel = 4'd2; rd_adr = 9'd3; cyc();
    rd_adr = 9'd1; cyc();
    load = 1'b0; cyc(); cyc();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/fft_agu_ctrl.md
Name: fft_agu_ctrl

Overview:
- Parametrised successor to the fixed-size FFT control unit: address-generation and sequencing for an in-place radix-2 DIT FFT over two ping-pong dual-port banks.
- Transform size is selected at run time, from 2^MIN_M to 2^MAX_M points.
- Handles a butterfly datapath with configurable pipeline latency BF_LAT, flushing the pipeline at every stage boundary.
- Sits between the sample loader, the butterfly unit, the twiddle ROM (sized for 2^MAX_M) and the output reader.

Parameters:
- bit_width, 16, datapath width; passed through only, with no effect on logic.
- MAX_M, 9, log2 of the largest FFT size. Twiddle ROM depth is 2^(MAX_M-1).
- MIN_M, 2, log2 of the smallest legal FFT size.
- BF_LAT, 2, butterfly read-to-write latency in cycles. Must be at least 1.
- MW, $clog2(MAX_M+1), width of m_sel.

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-low; clears all state.
- start  in  1  request a transform; sampled at a clk edge.
- load  in  1  level; writes one sample into bank0 each cycle it is high.
- m_sel  in  MW  log2 size; used live during LOAD, latched on an accepted start.
- rd_adr  in  MAX_M  natural-order index during LOAD and DONE.
- busy  out  1  high in ISSUE/FLUSH.
- done  out  1  level; high in DONE.
- err  out  1  one-cycle pulse on a rejected start.
- rd_sel  out  1  bank currently read: stage parity in ISSUE/FLUSH, result bank in DONE.
- we0, we1  out  1 each  bank write enables, covering both ports a and b.
- adr0_a, adr0_b, adr1_a, adr1_b  out  MAX_M each  bank addresses.
- twiddle_adr  out  MAX_M-1  twiddle ROM address.

Behaviour:
- Reset (reset=0): state goes to IDLE. All outputs are 0. The delay line is cleared. Assertion mid-transform aborts it immediately; there is no completion.
- States are IDLE, LOAD, ISSUE, FLUSH, DONE.
- IDLE/DONE/LOAD with load=1 go to LOAD. The LOAD state is left as soon as load falls.
  - In LOAD: we0=1, adr0_a = bit-reverse of rd_adr[m_sel-1:0]; upper bits are 0.
- start=1 with load=0 in IDLE/DONE/LOAD:
  - If MIN_M<=m_sel<=MAX_M: latch m = m_sel, set stage s=0 and butterfly index b=0, go to ISSUE.
  - Otherwise: state is unchanged and err pulses for one cycle.
- start and load both high: load wins; start is ignored.
- start and load are ignored while busy.
- ISSUE: one butterfly per cycle, b = 0 .. 2^(m-1)-1.
  - span = 1<<s; pos = b & (span-1); grp = b>>s.
  - adr_a = (grp<<(s+1)) | pos; adr_b = adr_a + span.
  - twiddle_adr = pos << (MAX_M-1-s).
  - The read bank is s[0]: read addresses go on adrX_a/adrX_b of that bank.
- Write side: adr_a, adr_b and a valid bit travel through a BF_LAT-deep delay line. On the other bank, we = delayed valid and addresses = delayed adr_a/adr_b.
- After the last b, go to FLUSH for exactly BF_LAT cycles. No issue happens in FLUSH; writes continue. No read and write ever target the same bank in the same cycle.
- At the end of FLUSH:
  - If s<m-1: s++, b=0, return to ISSUE.
  - Otherwise: go to DONE.
- Latency: start sampled at edge E0 gives done=1 after edge E0 + m*(2^(m-1)+BF_LAT).
- DONE: result bank is m[0]. rd_sel = m[0]. That bank's adr_a = rd_adr; we0=we1=0. done stays high until the next accepted load or start.
- Unused address outputs are driven to 0 in every state.
- All counters wrap-free: b is never compared beyond 2^(m-1)-1.

Decomposition:
- Package fft_agu_pkg:
  - state_t enum {IDLE, LOAD, ISSUE, FLUSH, DONE}.
  - Default MAX_M and MIN_M.
  - Function bitrev(value, m).
- Sub-module fft_agu_delay: BF_LAT-stage shift register of {valid, adr_a, adr_b} with async active-low clear.

Test Plan:
- Reset mid-ISSUE (m_sel=9, drop reset at cycle 40) -> all outputs 0 in the same cycle; idle until start.
- LOAD with m_sel=3, rd_adr=1,3,6 -> we0=1, adr0_a=4,6,3.
- LOAD with m_sel=9, rd_adr=5 -> adr0_a=320.
- m_sel=3, BF_LAT=2, start -> stage0 adr0_a=0,2,4,6 / adr0_b=1,3,5,7 / twiddle 0, with we1 two cycles later carrying the same addresses.
- Same run, stage2 -> adr0_a=0..3, adr0_b=4..7, twiddle_adr=0,64,128,192. done rises exactly 18 cycles after the start edge; rd_sel=1 in DONE.
- m_sel=1 (illegal) with start -> err single pulse; state stays IDLE; busy=0.
- start and load high together -> LOAD entered; busy stays 0.
- m_sel=4 -> done after 4*(8+2)=40 cycles; rd_sel=0; adr0_a follows rd_adr in DONE.
